ddr_arbiter: RTL and testbench
==============================

Name: ddr_arbiter

Overview:
- Request arbiter sitting directly upstream of the DDR controller; owns the controller's read/write/refresh inputs.
- Multiplexes two clients onto the controller's single-outstanding-operation interface:
  - the VGA line-fetch read client;
  - the drawing-engine write client.
- Generates the periodic auto-refresh pulse itself.
- Clocked on the rising edge of clk133_p. The controller samples on the falling edge, so every arbiter output is stable half a cycle before it is used.

Parameters:
- INIT_WAIT, 27000: cycles after reset release before any command is driven. Covers the controller power-up sequence, which takes about 26820 cycles.
- REFRESH_INTERVAL, 1030: cycles between refresh requests (7.8 us at 133 MHz, with margin).
- REFRESH_GUARD, 14: cycles the arbiter idles after pulsing refresh. Covers tRFC plus 3 cycles of slack.
- MAX_READ_RUN, 8: consecutive read grants allowed while a write waits. Used only with DDR_ARB_FAIRNESS_EN.

Ports:
- clk133_p  in  1  system 133 MHz clock, rising-edge logic.
- rst_n  in  1  asynchronous active-low reset.
- rdReq  in  1  read client request; level, held until rdValid.
- rdAddr  in  24  read word address; stable while rdReq is high.
- rdValid  out  1  one-cycle pulse; rdData is valid.
- rdData  out  16  read result, registered.
- wrReq  in  1  write client request; level, held until wrDone.
- wrAddr  in  24  write word address.
- wrData  in  16  write data.
- wrDone  out  1  one-cycle pulse; write committed.
- read  out  1  to controller.
- readAddress  out  24  to controller.
- readAcknowledge  in  1  from controller; one-cycle pulse.
- readData  in  16  from controller; valid when readAcknowledge is high.
- write  out  1  to controller.
- writeAddress  out  24  to controller.
- writeData  out  16  to controller.
- writeAcknowledge  in  1  from controller; one-cycle pulse.
- refresh  out  1  to controller; one-cycle pulse.
- refreshOverrun  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = WAIT_INIT.
  - All outputs 0, including addresses and data.
  - Init counter, refresh counter, refreshPending and the read-run counter cleared.
  - Reset mid-operation abandons the transaction silently; no rdValid or wrDone is issued.
- WAIT_INIT:
  - Init counter increments each cycle.
  - When it reaches INIT_WAIT-1: go to IDLE and start the refresh counter.
  - Client requests are ignored until then.
- Refresh timer (active from IDLE onward):
  - Counter runs 0..REFRESH_INTERVAL-1 and wraps.
  - On wrap, set refreshPending.
  - If refreshPending is already set at a wrap, set refreshOverrun. It stays set until reset.
- IDLE: priority is evaluated each cycle, first match wins.
  1. refreshPending: refresh=1 for exactly one cycle, clear refreshPending, load guard counter to REFRESH_GUARD-1, go to REFRESH.
  2. rdReq: latch rdAddr into readAddress, read=1, go to READ.
  3. wrReq: latch wrAddr into writeAddress and wrData into writeData, write=1, go to WRITE.
- READ:
  - Hold read=1 and readAddress until readAcknowledge is sampled high.
  - On that cycle: read=0, rdData<=readData, rdValid=1 for the next cycle, go to IDLE.
- WRITE:
  - Hold write=1, writeAddress and writeData until writeAcknowledge is sampled high.
  - On that cycle: write=0, wrDone=1 for one cycle, go to IDLE.
- REFRESH:
  - refresh=0.
  - Guard counter decrements; go to IDLE when it reaches 0.
- Invariants:
  - read, write and refresh are mutually exclusive, and at most one is ever high.
  - No new command is issued in the same cycle an acknowledge is seen.
  - A client's request is granted at the earliest one cycle after the previous transaction's done pulse.
- Client rules:
  - A client must keep req high until its done/valid pulse.
  - If req is dropped early, the transaction still completes; the done/valid pulse is issued and may be ignored.
- Simultaneous events:
  - Refresh wrap while in READ or WRITE: refreshPending waits for IDLE.
  - rdReq and wrReq together: read wins, subject to the optional feature.
- Latency from the IDLE grant to rdValid equals the controller's read latency plus 1 cycle.

Optional Feature:
- Macro: DDR_ARB_FAIRNESS_EN.
- Defined:
  - The read-run counter increments on each read grant made while wrReq is high.
  - It clears on any write grant, or on a read grant with wrReq low.
  - When the counter equals MAX_READ_RUN and wrReq is high, the write is granted ahead of the read. Refresh still has the highest priority.
- Not defined:
  - Strict read-over-write priority; writes may starve indefinitely.
  - No counter logic is synthesised.

Test Plan:
1. Reset, then idle: read/write/refresh stay 0 for 26999 cycles; the first refresh pulse occurs REFRESH_INTERVAL cycles after IDLE entry, then every 1030 cycles, each exactly 1 cycle wide.
2. Single read: rdReq=1, rdAddr=24'h12_3456; the controller model acks after 10 cycles with readData=16'hBEEF → readAddress=24'h123456, read held 10 cycles, rdValid pulse with rdData=16'hBEEF, read low before the model's next falling-edge sample.
3. Single write: wrAddr=24'h00_0010, wrData=16'hA5A5; ack after 8 cycles → writeAddress/writeData held constant throughout, exactly one wrDone pulse, write low after the ack.
4. Refresh collision: the refresh wrap lands mid-read → the read completes; refresh pulses the first cycle back in IDLE; no read or write is asserted during the following 14 guard cycles, even with rdReq held.
5. Contention: rdReq and wrReq continuously high → without the macro, the write is never granted over 50 reads; with DDR_ARB_FAIRNESS_EN, the write is granted after every 8 reads.
6. Overrun and reset: hold the controller model's ack off for more than 2060 cycles → refreshOverrun=1. Assert rst_n=0 mid-read → all outputs 0 immediately, no rdValid issued, WAIT_INIT restarts.

Source files
------------

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: request arbiter in front of the DDR controller.
// Multiplexes the VGA line-fetch read client and the drawing-engine write
// client onto the controller's single-outstanding-operation interface and
// generates the periodic auto-refresh pulse.
// All logic runs on the rising edge of clk133_p. The controller samples on
// the falling edge, so every output is registered and settles half a cycle
// before it is used.
//
// Optional build macro: DDR_ARB_FAIRNESS_EN
//   When defined, after MAX_READ_RUN consecutive read grants made while a
//   write waits, the write is granted ahead of the next read.
//   When undefined, reads always win over writes.
//
// Ports:
//   clk133_p          in   133 MHz system clock (rising edge)
//   rst_n             in   asynchronous active-low reset
//   rdReq/rdAddr      in   read client request level / word address
//   rdValid/rdData    out  one-cycle pulse / registered read result
//   wrReq/wrAddr/wrData in write client request level / address / data
//   wrDone            out  one-cycle pulse, write committed
//   read/readAddress  out  controller read command / address
//   readAcknowledge/readData in controller read completion pulse / data
//   write/writeAddress/writeData out controller write command / addr / data
//   writeAcknowledge  in   controller write completion pulse
//   refresh           out  one-cycle auto-refresh pulse
//   refreshOverrun    out  sticky flag, a refresh interval elapsed with the
//                          previous refresh still unserviced
module ddr_arbiter #(
  parameter int unsigned INIT_WAIT        = 27000,
  parameter int unsigned REFRESH_INTERVAL = 1030,
  parameter int unsigned REFRESH_GUARD    = 14,
  parameter int unsigned MAX_READ_RUN     = 8
) (
  input  logic        clk133_p,
  input  logic        rst_n,
  input  logic        rdReq,
  input  logic [23:0] rdAddr,
  output logic        rdValid,
  output logic [15:0] rdData,
  input  logic        wrReq,
  input  logic [23:0] wrAddr,
  input  logic [15:0] wrData,
  output logic        wrDone,
  output logic        read,
  output logic [23:0] readAddress,
  input  logic        readAcknowledge,
  input  logic [15:0] readData,
  output logic        write,
  output logic [23:0] writeAddress,
  output logic [15:0] writeData,
  input  logic        writeAcknowledge,
  output logic        refresh,
  output logic        refreshOverrun
);

  localparam int unsigned INIT_W  = (INIT_WAIT > 1)        ? $clog2(INIT_WAIT)        : 1;
  localparam int unsigned REF_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned GUARD_W = (REFRESH_GUARD > 1)    ? $clog2(REFRESH_GUARD)    : 1;

  localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_WAIT - 1);
  localparam logic [INIT_W-1:0]  INIT_ONE   = INIT_W'(1);
  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_INTERVAL - 1);
  localparam logic [REF_W-1:0]   REF_ONE    = REF_W'(1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(REFRESH_GUARD - 1);
  localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(1);

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_REFRESH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [INIT_W-1:0]  r_init_cnt;
  logic [REF_W-1:0]   r_ref_cnt;
  logic [GUARD_W-1:0] r_guard_cnt;
  logic               r_refresh_pending;

  logic               w_ref_wrap;
  logic               w_idle_free;
  logic               w_grant_ref;
  logic               w_grant_rd;
  logic               w_grant_wr;
  logic               w_wr_first;

  logic               w_read_nxt;
  logic               w_write_nxt;
  logic               w_refresh_nxt;
  logic               w_rd_valid_nxt;
  logic               w_wr_done_nxt;

  // Grant decode. Refresh always wins; otherwise read beats write unless
  // the fairness counter says the waiting write has been passed over enough.
  assign w_idle_free = (r_state == ST_IDLE) && !r_refresh_pending;
  assign w_grant_ref = (r_state == ST_IDLE) &&  r_refresh_pending;
  assign w_grant_rd  = w_idle_free && rdReq && !w_wr_first;
  assign w_grant_wr  = w_idle_free && wrReq && (!rdReq || w_wr_first);

`ifdef DDR_ARB_FAIRNESS_EN
  localparam int unsigned     RUN_W   = $clog2(MAX_READ_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_READ_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] r_run_cnt;

  assign w_wr_first = wrReq && (r_run_cnt == RUN_MAX);

  // Counts reads granted while a write was waiting; any write grant or a
  // read grant with no write waiting restarts the run.
  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      r_run_cnt <= '0;
    end else if (w_grant_wr) begin
      r_run_cnt <= '0;
    end else if (w_grant_rd) begin
      if (!wrReq) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != RUN_MAX) begin
        r_run_cnt <= r_run_cnt + RUN_ONE;
      end
    end
  end
`else
  // Strict read priority; MAX_READ_RUN has no effect in this build.
  assign w_wr_first = 1'b0 && (MAX_READ_RUN != 0);
`endif

  // State register
  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_INIT: begin
        if (r_init_cnt == INIT_LAST) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_grant_ref)     w_state_nxt = ST_REFRESH;
        else if (w_grant_rd) w_state_nxt = ST_READ;
        else if (w_grant_wr) w_state_nxt = ST_WRITE;
      end
      ST_READ: begin
        if (readAcknowledge) w_state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        if (writeAcknowledge) w_state_nxt = ST_IDLE;
      end
      ST_REFRESH: begin
        if (r_guard_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_WAIT_INIT;
    endcase
  end

  // Output logic: next values of the registered command/handshake outputs.
  // Commands drop on the acknowledge cycle and can only be re-issued from
  // IDLE one cycle later.
  always_comb begin
    w_read_nxt     = 1'b0;
    w_write_nxt    = 1'b0;
    w_refresh_nxt  = 1'b0;
    w_rd_valid_nxt = 1'b0;
    w_wr_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_refresh_nxt = w_grant_ref;
        w_read_nxt    = w_grant_rd;
        w_write_nxt   = w_grant_wr;
      end
      ST_READ: begin
        w_read_nxt     = !readAcknowledge;
        w_rd_valid_nxt =  readAcknowledge;
      end
      ST_WRITE: begin
        w_write_nxt   = !writeAcknowledge;
        w_wr_done_nxt =  writeAcknowledge;
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      read         <= 1'b0;
      write        <= 1'b0;
      refresh      <= 1'b0;
      rdValid      <= 1'b0;
      wrDone       <= 1'b0;
      readAddress  <= '0;
      writeAddress <= '0;
      writeData    <= '0;
      rdData       <= '0;
    end else begin
      read    <= w_read_nxt;
      write   <= w_write_nxt;
      refresh <= w_refresh_nxt;
      rdValid <= w_rd_valid_nxt;
      wrDone  <= w_wr_done_nxt;
      if (w_grant_rd) begin
        readAddress <= rdAddr;
      end
      if (w_grant_wr) begin
        writeAddress <= wrAddr;
        writeData    <= wrData;
      end
      if (w_rd_valid_nxt) begin
        rdData <= readData;
      end
    end
  end

  // Power-up wait counter
  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt <= '0;
    end else if ((r_state == ST_WAIT_INIT) && (r_init_cnt != INIT_LAST)) begin
      r_init_cnt <= r_init_cnt + INIT_ONE;
    end
  end

  // Refresh interval timer, free-running once IDLE has been reached
  assign w_ref_wrap = (r_state != ST_WAIT_INIT) && (r_ref_cnt == REF_LAST);

  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
    end else if (r_state != ST_WAIT_INIT) begin
      r_ref_cnt <= w_ref_wrap ? '0 : (r_ref_cnt + REF_ONE);
    end
  end

  // A wrap that coincides with the refresh grant re-arms the request; it is
  // only an overrun if the earlier request is still waiting.
  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh_pending <= 1'b0;
      refreshOverrun    <= 1'b0;
    end else begin
      if (w_ref_wrap) begin
        r_refresh_pending <= 1'b1;
      end else if (w_grant_ref) begin
        r_refresh_pending <= 1'b0;
      end
      if (w_ref_wrap && r_refresh_pending && !w_grant_ref) begin
        refreshOverrun <= 1'b1;
      end
    end
  end

  // Post-refresh guard counter
  always_ff @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      r_guard_cnt <= '0;
    end else if (w_grant_ref) begin
      r_guard_cnt <= GUARD_LAST;
    end else if ((r_state == ST_REFRESH) && (r_guard_cnt != '0)) begin
      r_guard_cnt <= r_guard_cnt - GUARD_ONE;
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
// Self-checking bench for ddr_arbiter: controller model with programmable
// acknowledge latency, client-side memory reference model, bus monitor.
`timescale 1ns/1ps
module tb_ddr_arbiter;

  localparam int unsigned INIT_WAIT = 27000;
  localparam int unsigned RI        = 1030;
  localparam int unsigned RG        = 14;
  localparam int unsigned MRR       = 8;

  logic        clk133_p = 1'b0;
  logic        rst_n    = 1'b0;
  logic        rdReq    = 1'b0;
  logic [23:0] rdAddr   = '0;
  logic        rdValid;
  logic [15:0] rdData;
  logic        wrReq    = 1'b0;
  logic [23:0] wrAddr   = '0;
  logic [15:0] wrData   = '0;
  logic        wrDone;
  logic        read;
  logic [23:0] readAddress;
  logic        readAcknowledge;
  logic [15:0] readData;
  logic        write;
  logic [23:0] writeAddress;
  logic [15:0] writeData;
  logic        writeAcknowledge;
  logic        refresh;
  logic        refreshOverrun;

  ddr_arbiter #(
    .INIT_WAIT(INIT_WAIT),
    .REFRESH_INTERVAL(RI),
    .REFRESH_GUARD(RG),
    .MAX_READ_RUN(MRR)
  ) dut (
    .clk133_p(clk133_p), .rst_n(rst_n),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdValid(rdValid), .rdData(rdData),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrDone(wrDone),
    .read(read), .readAddress(readAddress),
    .readAcknowledge(readAcknowledge), .readData(readData),
    .write(write), .writeAddress(writeAddress), .writeData(writeData),
    .writeAcknowledge(writeAcknowledge),
    .refresh(refresh), .refreshOverrun(refreshOverrun)
  );

  always #4 clk133_p = ~clk133_p;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk133_p);
  endtask

  // Rising edges since reset release (edge k after release gives cyc == k)
  int cyc;
  always @(posedge clk133_p or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Controller model: samples commands on the falling edge and acknowledges
  // after the programmed number of sampled command cycles.
  int unsigned  rd_lat = 10;
  int unsigned  wr_lat = 8;
  bit           hold_ack = 1'b0;
  int unsigned  rd_cnt, wr_cnt;
  logic [15:0]  ctl_mem [logic [23:0]];
  logic [23:0]  ctl_raddr, ctl_waddr;
  logic [15:0]  ctl_wdata;

  always @(negedge clk133_p or negedge rst_n) begin
    if (!rst_n) begin
      readAcknowledge  <= 1'b0;
      writeAcknowledge <= 1'b0;
      readData         <= '0;
      rd_cnt           <= 0;
      wr_cnt           <= 0;
    end else begin
      readAcknowledge  <= 1'b0;
      writeAcknowledge <= 1'b0;
      if (read) begin
        if (!hold_ack && (rd_cnt + 1 >= rd_lat)) begin
          readAcknowledge <= 1'b1;
          readData  <= ctl_mem.exists(readAddress) ? ctl_mem[readAddress] : ~readAddress[15:0];
          ctl_raddr <= readAddress;
          rd_cnt    <= 0;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (write) begin
        if (!hold_ack && (wr_cnt + 1 >= wr_lat)) begin
          writeAcknowledge <= 1'b1;
          ctl_mem[writeAddress] = writeData;
          ctl_waddr <= writeAddress;
          ctl_wdata <= writeData;
          wr_cnt    <= 0;
        end else begin
          wr_cnt <= wr_cnt + 1;
        end
      end
    end
  end

  // Bus monitor
  int   ref_times[$];
  byte  grants[$];
  int   grant_cyc[$];
  int   rd_grants = 0, wr_grants = 0, rd_high = 0, rdv_cnt = 0, wrd_cnt = 0;
  int   viol_excl = 0, viol_refw = 0, viol_stab = 0, viol_pulse = 0;
  logic p_read = 0, p_write = 0, p_refresh = 0, p_rdv = 0, p_wrd = 0;
  logic [23:0] p_raddr, p_waddr;
  logic [15:0] p_wdata;

  always @(negedge clk133_p) begin
    if (rst_n) begin
      if (int'(read) + int'(write) + int'(refresh) > 1) viol_excl <= viol_excl + 1;
      if (refresh) begin
        ref_times.push_back(cyc);
        if (p_refresh) viol_refw <= viol_refw + 1;
      end
      if ((read && p_read && readAddress !== p_raddr) ||
          (write && p_write && (writeAddress !== p_waddr || writeData !== p_wdata)))
        viol_stab <= viol_stab + 1;
      if (read && !p_read) begin
        grants.push_back(0); grant_cyc.push_back(cyc); rd_grants <= rd_grants + 1;
      end
      if (write && !p_write) begin
        grants.push_back(1); grant_cyc.push_back(cyc); wr_grants <= wr_grants + 1;
      end
      if (read)    rd_high <= rd_high + 1;
      if (rdValid) rdv_cnt <= rdv_cnt + 1;
      if (wrDone)  wrd_cnt <= wrd_cnt + 1;
      if ((rdValid && p_rdv) || (wrDone && p_wrd)) viol_pulse <= viol_pulse + 1;
    end
    p_read <= read; p_write <= write; p_refresh <= refresh;
    p_rdv <= rdValid; p_wrd <= wrDone;
    p_raddr <= readAddress; p_waddr <= writeAddress; p_wdata <= writeData;
  end

  // Client-side reference memory: what a read of an address must return
  logic [15:0] ref_mem [logic [23:0]];

  function automatic logic [15:0] ref_read(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a[15:0];
  endfunction

  task automatic do_read(input logic [23:0] a, input int unsigned lat, input string tag);
    logic [15:0] exp;
    int n;
    exp    = ref_read(a);
    rd_lat = lat;
    rdAddr = a;
    rdReq  = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (!rdValid && n < 3000);
    chk({tag, "_valid"}, rdValid, 1'b1);
    chk({tag, "_data"}, rdData, exp);
    chk({tag, "_addr"}, ctl_raddr, a);
    chk({tag, "_readlow"}, read, 1'b0);
    rdReq = 1'b0;
  endtask

  task automatic do_write(input logic [23:0] a, input logic [15:0] d,
                          input int unsigned lat, input string tag);
    int n;
    wr_lat = lat;
    wrAddr = a;
    wrData = d;
    wrReq  = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (!wrDone && n < 3000);
    chk({tag, "_done"}, wrDone, 1'b1);
    chk({tag, "_addr"}, ctl_waddr, a);
    chk({tag, "_data"}, ctl_wdata, d);
    chk({tag, "_writelow"}, write, 1'b0);
    wrReq = 1'b0;
    ref_mem[a] = d;
  endtask

  int n, r0, w0, c0, g0, rfc, lat, reads, writes, run, bad_runs, rdv0;
  logic [23:0] a;
  logic [15:0] d;

  initial begin
    ctl_mem[24'h123456] = 16'hBEEF;
    ref_mem[24'h123456] = 16'hBEEF;
    tick(3);
    rst_n = 1'b1;

    // 1. Idle after reset: no commands, refresh at fixed period
    chk("reset_outs", {read, write, refresh, rdValid, wrDone, refreshOverrun}, '0);
    n = 0;
    while (cyc < INIT_WAIT + 2 * RI + 20 && n < 40000) begin tick(1); n++; end
    chk("init_no_cmd", grants.size(), 0);
    chk("ref_count", ref_times.size(), 2);
    chk("ref_first", ref_times[0], INIT_WAIT + RI + 1);
    chk("ref_period", ref_times[1] - ref_times[0], RI);

    // 2. Single read
    r0 = rd_high; rdv0 = rdv_cnt;
    do_read(24'h123456, 10, "rd1");
    chk("rd1_beef", rdData, 16'hBEEF);
    tick(3);
    chk("rd1_held", rd_high - r0, 10);
    chk("rd1_onevalid", rdv_cnt - rdv0, 1);

    // 3. Single write
    w0 = wrd_cnt;
    do_write(24'h000010, 16'hA5A5, 8, "wr1");
    tick(3);
    chk("wr1_onedone", wrd_cnt - w0, 1);

    // Randomized read/write traffic against the reference memory
    for (int i = 0; i < 24; i++) begin
      a = 24'h5A0000 | 24'($urandom_range(0, 7));
      d = 16'($urandom);
      lat = $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) do_write(a, d, lat, "rnd_wr");
      else                           do_read(a, lat, "rnd_rd");
      tick($urandom_range(0, 3));
    end

    // 4. Refresh wrap lands mid-read
    c0 = ref_times.size();
    n = 0;
    while (ref_times.size() == c0 && n < 2000) begin tick(1); n++; end
    chk("coll_sync", ref_times.size(), c0 + 1);
    tick(20);
    c0 = ref_times.size();
    g0 = grants.size();
    do_read(24'h000777, 1040, "coll_rd");
    chk("coll_no_ref_during", ref_times.size(), c0);
    do_read(24'h000778, 2, "coll_rd2");
    tick(2);
    chk("coll_ref_seen", ref_times.size(), c0 + 1);
    chk("coll_grants", grants.size(), g0 + 2);
    if (ref_times.size() == c0 + 1 && grants.size() == g0 + 2) begin
      rfc = ref_times[c0];
      chk("coll_ref_time", rfc, grant_cyc[g0] + 1040 + 1);
      chk("coll_guard", grant_cyc[g0 + 1] - rfc, RG + 1);
    end

    // 5. Read/write contention
    g0 = grants.size();
    r0 = rd_grants;
    rd_lat = 3; wr_lat = 3;
    rdAddr = 24'h000100; wrAddr = 24'h000200; wrData = 16'h1234;
    ref_mem[24'h000200] = 16'h1234;
    rdReq = 1'b1; wrReq = 1'b1;
    n = 0;
    while (rd_grants - r0 < 50 && n < 4000) begin tick(1); n++; end
    rdReq = 1'b0; wrReq = 1'b0;
    tick(40);
    reads = 0; writes = 0; run = 0; bad_runs = 0;
    for (int i = g0; i < grants.size() && reads < 50; i++) begin
      if (grants[i] == 0) begin
        reads++; run++;
      end else begin
        writes++;
        if (run != MRR) bad_runs++;
        run = 0;
      end
    end
    chk("cont_reads", reads, 50);
`ifdef DDR_ARB_FAIRNESS_EN
    chk("cont_writes", writes, 50 / MRR);
    chk("cont_runlen", bad_runs, 0);
`else
    chk("cont_writes", writes, 0);
`endif

    // 6. Overrun while the controller stalls a read
    chk("ovr_before", refreshOverrun, 1'b0);
    hold_ack = 1'b1;
    rd_lat = 2;
    rdAddr = 24'h000300;
    rdReq = 1'b1;
    tick(2 * RI + 40);
    chk("ovr_set", refreshOverrun, 1'b1);
    hold_ack = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (!rdValid && n < 100);
    chk("ovr_rd_done", rdValid, 1'b1);
    chk("ovr_rd_data", rdData, ref_read(24'h000300));
    rdReq = 1'b0;
    tick(5);
    chk("ovr_sticky", refreshOverrun, 1'b1);

    // Reset mid-read
    rd_lat = 20;
    rdAddr = 24'h000400;
    rdReq = 1'b1;
    n = 0;
    do begin tick(1); n++; end while (!read && n < 100);
    tick(3);
    chk("rst_pre_read", read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", {read, write, refresh, rdValid, wrDone, refreshOverrun,
                     readAddress, writeAddress, writeData, rdData}, '0);
    rdv0 = rdv_cnt;
    tick(3);
    rst_n = 1'b1;
    rdAddr = 24'h000401;
    g0 = grants.size();
    n = 0;
    while (grants.size() == g0 && n < INIT_WAIT + 100) begin tick(1); n++; end
    chk("rst_regrant", grants.size(), g0 + 1);
    if (grants.size() == g0 + 1) chk("rst_init_wait", grant_cyc[g0], INIT_WAIT + 1);
    chk("rst_no_valid", rdv_cnt - rdv0, 0);
    chk("rst_ovr_clr", refreshOverrun, 1'b0);
    do_read(24'h000401, 4, "post_rst");
    tick(5);

    chk("excl", viol_excl, 0);
    chk("ref_width", viol_refw, 0);
    chk("stable", viol_stab, 0);
    chk("pulse_width", viol_pulse, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
